// File: rtl/shake_job_sched.sv
// rtl/shake_job_sched.sv - job FIFO and issue FSM in front of the MAYO SHAKE core.
// Optional watchdog enabled by defining SHAKE_SCHED_TIMEOUT_EN.
module shake_job_sched #(
  parameter int DEPTH          = 4,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         job_valid,
  output logic                         job_ready,
  input  logic [31:0]                  job_mlen,
  input  logic [31:0]                  job_olen,
  input  logic [31:0]                  job_read_adr,
  input  logic [31:0]                  job_write_adr,
  output logic                         shake_en,
  output logic [31:0]                  shake_mlen,
  output logic [31:0]                  shake_olen,
  output logic [31:0]                  shake_read_adr,
  output logic [31:0]                  shake_write_adr,
  input  logic                         shake_done,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   pending,
  output logic                         cmpl_valid,
  output logic                         cmpl_err,
  output logic [CNT_W-1:0]             jobs_done,
  output logic                         timeout_flag
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_COMPLETE,
    S_REJECT
  } state_t;

  state_t         state_q, state_d;
  logic [127:0]   fifo_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           ready_q, ready_d;
  logic           err_q, err_d;
  logic [CNT_W-1:0] jobs_done_q, jobs_done_d;
  logic           push, pop;
  logic [127:0]   head;
  logic [31:0]    next_olen;
  logic           wd_expire;

  // Entry layout: {mlen, olen, read_adr, write_adr}
  assign head      = fifo_q[rd_ptr_q];
  assign next_olen = fifo_q[rd_ptr_q + AW'(1)][95:64];
  assign push      = job_valid && ready_q;
  assign pop       = (state_q == S_ISSUE) || (state_q == S_REJECT);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= {job_mlen, job_olen, job_read_adr, job_write_adr};
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ready_d = (count_d != CW'(DEPTH));
  end

`ifdef SHAKE_SCHED_TIMEOUT_EN
  logic [31:0] wd_q, wd_d;
  logic        timeout_flag_q, timeout_flag_d;

  // Counter sits at zero outside WAIT, so it is cleared on every WAIT entry.
  always_comb begin
    wd_d           = (state_q == S_WAIT) ? wd_q + 32'd1 : 32'd0;
    timeout_flag_d = timeout_flag_q | wd_expire;
  end

  assign wd_expire    = (state_q == S_WAIT) && !shake_done &&
                        (wd_q == 32'(TIMEOUT_CYCLES - 1));
  assign timeout_flag = timeout_flag_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q           <= 32'd0;
      timeout_flag_q <= 1'b0;
    end else begin
      wd_q           <= wd_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
  assign wd_expire      = 1'b0;
  assign timeout_flag   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ready_q     <= 1'b1;
      err_q       <= 1'b0;
      jobs_done_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      jobs_done_q <= jobs_done_d;
    end
  end

  // REJECT pops the head this cycle, so the decision looks one entry further.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_COMPLETE: begin
        if (count_q != '0) begin
          state_d = (head[95:64] == 32'd0) ? S_REJECT : S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (shake_done || wd_expire) begin
          state_d = S_COMPLETE;
        end
      end
      S_REJECT: begin
        if (count_q > CW'(1)) begin
          state_d = (next_olen == 32'd0) ? S_REJECT : S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    err_d       = (state_q == S_WAIT) ? wd_expire : err_q;
    jobs_done_d = jobs_done_q;
    if ((state_q == S_COMPLETE) && !err_q) begin
      jobs_done_d = jobs_done_q + CNT_W'(1);
    end
  end

  always_comb begin
    shake_en        = (state_q == S_ISSUE);
    shake_mlen      = shake_en ? head[127:96] : 32'd0;
    shake_olen      = shake_en ? head[95:64]  : 32'd0;
    shake_read_adr  = shake_en ? head[63:32]  : 32'd0;
    shake_write_adr = shake_en ? head[31:0]   : 32'd0;
    cmpl_valid      = (state_q == S_COMPLETE) || (state_q == S_REJECT);
    cmpl_err        = (state_q == S_REJECT) || ((state_q == S_COMPLETE) && err_q);
    busy            = (state_q != S_IDLE) || (count_q != '0);
    pending         = count_q;
    job_ready       = ready_q;
    jobs_done       = jobs_done_q;
  end

endmodule
